// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and the future receiver.
//   - uart_state_t : frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   - clog2()      : ceiling log2 for elaboration-time widths
//   - clks_per_bit(): clocks per line bit; truncating integer division, kept
//                    here so the receiver derives bit timing identically.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Number of bits needed to hold the values 0..value-1 (minimum 0).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int clks_per_bit(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Free-running bit-period counter, 0..CLKS_PER_BIT-1, shared by TX and RX.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high reset (count -> 0)
//   clear : synchronous restart of the bit period (count -> 0)
//   tick  : high for the single cycle in which the count is at terminal value
// Parameter:
//   CLKS_PER_BIT : clocks per line bit (>= 2)
// -----------------------------------------------------------------------------
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == LAST_COUNT);
  assign tick      = w_at_last;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (w_at_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// Byte-wide valid/ready in, asynchronous serial line out. Frame:
// start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
// Each bit is held for CLKS_PER_BIT = CLOCK_HZ / BAUD clocks.
// Ports:
//   clock    : system clock
//   reset    : synchronous, active-high reset; abandons any frame in flight
//   in_data  : byte to send, sampled only on acceptance
//   in_valid : producer has a byte
//   in_ready : transmitter can accept (IDLE and not in reset)
//   tx       : serial line, straight from a flop, idles high
//   busy     : frame in progress
// Build option:
//   UART_TX_PARITY_EN : when defined, a parity bit (even, or odd when
//                       PARITY_ODD=1) is sent between data and stop bits.
// -----------------------------------------------------------------------------
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_HZ, BAUD);
  localparam int IDX_W        = clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  // Elaboration-time parameter checks.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_transmitter: CLOCK_HZ / BAUD must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_transmitter: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_transmitter: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_transmitter: PARITY_ODD must be 0 or 1");
  end

  uart_state_t          r_state;
  uart_state_t          w_state_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [IDX_W-1:0]     w_bit_idx_next;
  logic                 r_tx;
  logic                 w_tx_next;
  logic                 w_tick;
  logic                 w_accept;
  logic                 w_idle;

  assign w_idle   = (r_state == IDLE);
  assign in_ready = w_idle && !reset;
  assign busy     = !w_idle;
  assign tx       = r_tx;
  assign w_accept = in_valid && in_ready;

  // Counter is held at zero while idle, so the start bit gets a full period
  // beginning the cycle after acceptance.
  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock(clock),
    .reset(reset),
    .clear(w_idle),
    .tick (w_tick)
  );

`ifdef UART_TX_PARITY_EN
  // Parity is fixed at acceptance from the latched byte.
  logic r_parity;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= (^in_data) ^ 1'(PARITY_ODD);
    end
  end
`endif

  // The tx flop is loaded with the level of the bit being entered, so the
  // line changes on the same edge as the state.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_tx_next      = r_tx;
    case (r_state)
      IDLE: begin
        w_tx_next = 1'b1;
        if (w_accept) begin
          w_state_next = START;
          w_shift_next = in_data;
          w_tx_next    = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next   = DATA;
          w_bit_idx_next = '0;
          w_tx_next      = r_shift[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == LAST_DATA) begin
            w_bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
            w_state_next   = PARITY;
            w_tx_next      = r_parity;
`else
            w_state_next   = STOP;
            w_tx_next      = 1'b1;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + IDX_W'(1);
            w_tx_next      = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          w_state_next   = STOP;
          w_bit_idx_next = '0;
          w_tx_next      = 1'b1;
        end
      end
`endif
      STOP: begin
        w_tx_next = 1'b1;
        if (w_tick) begin
          if (r_bit_idx == LAST_STOP) begin
            w_state_next   = IDLE;
            w_bit_idx_next = '0;
          end else begin
            w_bit_idx_next = r_bit_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_bit_idx_next = '0;
        w_tx_next      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
    end
  end

endmodule
